// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU core and its boot-time program loader.
package cpu_pkg;

    // Word-address width of the instruction/data RAM, equal to the PC slice width.
    localparam int RAM_ADDR_W     = 8;

    // Default idle-cycle limit between bytes of a frame before the loader gives up.
    localparam int LOADER_TIMEOUT = 100000;

    // Loader frame-parsing states: waiting for COUNT, high byte, low byte, checksum.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        CSUM = 2'd3
    } loader_state_t;

endpackage

// File: rtl/prog_loader_timer.sv
// Inter-byte watchdog for the program loader. Counts down from TIMEOUT-1 after
// every clear; expired is high once the count has reached zero.
module prog_loader_timer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = LOADER_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Reload on every accepted byte, otherwise count down while a frame is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD_VAL;
        end else if (run && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: turns a COUNT / data / CSUM byte stream into 16-bit RAM writes
// starting at address 0, holding the CPU until a checksum-verified image is in.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int TIMEOUT = LOADER_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              wr_en,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    loader_state_t     state, state_n;
    logic [8:0]        n_words, n_words_n;
    logic [8:0]        idx, idx_n;
    logic [7:0]        hi_byte, hi_n;
    logic [7:0]        xor_acc, xor_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [15:0]       wr_data_n;
    logic              wr_en_n, cpu_hold_n, busy_n, done_n, error_n;
    logic              expired, timed_out;

    prog_loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid),
        .run     (state != IDLE),
        .expired (expired)
    );

    // A byte arriving on the expiry cycle takes priority over the abort.
    assign timed_out = (state != IDLE) && !rx_valid && expired;

    // Frame parser: next state, word assembly, checksum folding and output values.
    always_comb begin
        state_n    = state;
        n_words_n  = n_words;
        idx_n      = idx;
        hi_n       = hi_byte;
        xor_n      = xor_acc;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        wr_en_n    = 1'b0;
        done_n     = 1'b0;
        cpu_hold_n = cpu_hold;
        busy_n     = busy;
        error_n    = error;

        unique case (state)
            IDLE: begin
                if (rx_valid) begin
                    n_words_n  = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    idx_n      = 9'd0;
                    xor_n      = 8'd0;
                    error_n    = 1'b0;
                    busy_n     = 1'b1;
                    cpu_hold_n = 1'b1;
                    state_n    = HI;
                end
            end
            HI: begin
                if (rx_valid) begin
                    hi_n    = rx_data;
                    xor_n   = xor_acc ^ rx_data;
                    state_n = LO;
                end
            end
            LO: begin
                if (rx_valid) begin
                    xor_n     = xor_acc ^ rx_data;
                    wr_addr_n = ADDR_W'(idx);
                    wr_data_n = {hi_byte, rx_data};
                    wr_en_n   = 1'b1;
                    idx_n     = idx + 9'd1;
                    state_n   = (idx == n_words - 9'd1) ? CSUM : HI;
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == xor_acc) begin
                        done_n     = 1'b1;
                        cpu_hold_n = 1'b0;
                    end else begin
                        error_n    = 1'b1;
                    end
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (timed_out) begin
            error_n = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
        end
    end

    // State and registered outputs; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            n_words  <= 9'd0;
            idx      <= 9'd0;
            hi_byte  <= 8'd0;
            xor_acc  <= 8'd0;
            wr_addr  <= '0;
            wr_data  <= 16'd0;
            wr_en    <= 1'b0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_n;
            n_words  <= n_words_n;
            idx      <= idx_n;
            hi_byte  <= hi_n;
            xor_acc  <= xor_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            wr_en    <= wr_en_n;
            cpu_hold <= cpu_hold_n;
            busy     <= busy_n;
            done     <= done_n;
            error    <= error_n;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random frames against a byte-level model.
module tb_prog_loader;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_en, cpu_hold, busy, done, error;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [15:0] exp_words[$];
    logic [7:0]  tx_q[$];
    int          done_cnt = 0;
    int          checks   = 0;
    int          errors   = 0;

    prog_loader #(
        .ADDR_W  (8),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Record every RAM write and done pulse; a write with the CPU released is an error.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_q.push_back({wr_addr, wr_data});
            checks++;
            if (cpu_hold !== 1'b1) begin
                errors++;
                $display("[TB] FAIL write_while_released: cpu_hold=%b required 1", cpu_hold);
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_queue(input int max_gap);
        foreach (tx_q[i]) begin
            if (i > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
            send_byte(tx_q[i]);
        end
    endtask

    // Reference frame: random words, XOR of all data bytes, optionally corrupted.
    task automatic make_frame(input int n, input bit good);
        logic [15:0] w;
        logic [7:0]  x;
        exp_words.delete();
        tx_q.delete();
        tx_q.push_back((n == 256) ? 8'h00 : 8'(n));
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            exp_words.push_back(w);
            tx_q.push_back(w[15:8]);
            tx_q.push_back(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
        end
        tx_q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        idle(2);
        checks += 7;
        if (wr_en    !== 1'b0)  begin errors++; $display("[TB] FAIL reset_wr_en: got %b want 0", wr_en); end
        if (wr_addr  !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_addr: got %h want 00", wr_addr); end
        if (wr_data  !== 16'h0) begin errors++; $display("[TB] FAIL reset_wr_data: got %h want 0000", wr_data); end
        if (cpu_hold !== 1'b0)  begin errors++; $display("[TB] FAIL reset_cpu_hold: got %b want 0", cpu_hold); end
        if (busy     !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        if (done     !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        if (error    !== 1'b0)  begin errors++; $display("[TB] FAIL reset_error: got %b want 0", error); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_good_frame();
        wr_q.delete(); done_cnt = 0;
        tx_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_byte(tx_q[0]);
        checks += 2;
        if (busy !== 1'b1)     begin errors++; $display("[TB] FAIL good_busy_rise: got %b want 1", busy); end
        if (cpu_hold !== 1'b1) begin errors++; $display("[TB] FAIL good_hold_rise: got %b want 1", cpu_hold); end
        send_byte(tx_q[1]);
        send_byte(tx_q[2]);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 8'h00 || wr_data !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL good_first_write: got en=%b %h@%h want 1 1234@00", wr_en, wr_data, wr_addr);
        end
        for (int i = 3; i < 6; i++) send_byte(tx_q[i]);
        checks += 4;
        if (done !== 1'b1)     begin errors++; $display("[TB] FAIL good_done: got %b want 1", done); end
        if (cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL good_hold_fall: got %b want 0", cpu_hold); end
        if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL good_busy_fall: got %b want 0", busy); end
        if (error !== 1'b0)    begin errors++; $display("[TB] FAIL good_error: got %b want 0", error); end
        idle(2);
        checks += 3;
        if (done_cnt != 1) begin errors++; $display("[TB] FAIL good_done_count: got %0d want 1", done_cnt); end
        if (wr_q.size() != 2) begin
            errors++; $display("[TB] FAIL good_write_count: got %0d want 2", wr_q.size());
        end else begin
            if (wr_q[0] !== {8'h00, 16'h1234}) begin errors++; $display("[TB] FAIL good_write0: got %h want 001234", wr_q[0]); end
            if (wr_q[1] !== {8'h01, 16'hABCD}) begin errors++; $display("[TB] FAIL good_write1: got %h want 01abcd", wr_q[1]); end
        end
    endtask

    task automatic test_bad_csum();
        wr_q.delete(); done_cnt = 0;
        tx_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_queue(0);
        idle(2);
        checks += 4;
        if (wr_q.size() != 2)  begin errors++; $display("[TB] FAIL bad_write_count: got %0d want 2", wr_q.size()); end
        if (error !== 1'b1)    begin errors++; $display("[TB] FAIL bad_error: got %b want 1", error); end
        if (cpu_hold !== 1'b1) begin errors++; $display("[TB] FAIL bad_hold: got %b want 1", cpu_hold); end
        if (done_cnt != 0)     begin errors++; $display("[TB] FAIL bad_done_count: got %0d want 0", done_cnt); end
        done_cnt = 0;
        make_frame(3, 1'b1);
        send_queue(2);
        idle(2);
        checks += 3;
        if (error !== 1'b0)    begin errors++; $display("[TB] FAIL recover_error: got %b want 0", error); end
        if (cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL recover_hold: got %b want 0", cpu_hold); end
        if (done_cnt != 1)     begin errors++; $display("[TB] FAIL recover_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random_frames();
        int n;
        bit good;
        for (int f = 0; f < 8; f++) begin
            n    = $urandom_range(1, 6);
            good = 1'($urandom_range(0, 1));
            make_frame(n, good);
            wr_q.delete(); done_cnt = 0;
            send_queue(3);
            idle(2);
            checks += 5;
            if (wr_q.size() != n) begin
                errors++; $display("[TB] FAIL rand_write_count[%0d]: got %0d want %0d", f, wr_q.size(), n);
            end else begin
                foreach (wr_q[i]) begin
                    checks++;
                    if (wr_q[i] !== {8'(i), exp_words[i]}) begin
                        errors++; $display("[TB] FAIL rand_write[%0d][%0d]: got %h want %h", f, i, wr_q[i], {8'(i), exp_words[i]});
                    end
                end
            end
            if (done_cnt != int'(good)) begin errors++; $display("[TB] FAIL rand_done[%0d]: got %0d want %0d", f, done_cnt, good); end
            if (error !== !good)        begin errors++; $display("[TB] FAIL rand_error[%0d]: got %b want %b", f, error, !good); end
            if (cpu_hold !== !good)     begin errors++; $display("[TB] FAIL rand_hold[%0d]: got %b want %b", f, cpu_hold, !good); end
            if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL rand_busy[%0d]: got %b want 0", f, busy); end
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        make_frame(256, 1'b1);
        wr_q.delete(); done_cnt = 0;
        send_queue(0);
        idle(2);
        checks += 3;
        if (wr_q.size() != 256) begin
            errors++; $display("[TB] FAIL b2b_write_count: got %0d want 256", wr_q.size());
        end else begin
            foreach (wr_q[i]) if (wr_q[i] !== {8'(i), exp_words[i]}) bad++;
            if (bad != 0) begin errors++; $display("[TB] FAIL b2b_write_content: got %0d bad writes want 0", bad); end
            if (wr_q[255].addr !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_last_addr: got %h want ff", wr_q[255].addr); end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("[TB] FAIL b2b_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_timeout();
        wr_q.delete(); done_cnt = 0;
        send_byte(8'h01);
        send_byte(8'h12);
        idle(TO - 1);
        checks += 2;
        if (error !== 1'b0) begin errors++; $display("[TB] FAIL to_early_error: got %b want 0", error); end
        if (busy !== 1'b1)  begin errors++; $display("[TB] FAIL to_early_busy: got %b want 1", busy); end
        idle(1);
        checks += 4;
        if (error !== 1'b1)    begin errors++; $display("[TB] FAIL to_error: got %b want 1", error); end
        if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL to_busy: got %b want 0", busy); end
        if (cpu_hold !== 1'b1) begin errors++; $display("[TB] FAIL to_hold: got %b want 1", cpu_hold); end
        if (wr_q.size() != 0)  begin errors++; $display("[TB] FAIL to_writes: got %0d want 0", wr_q.size()); end
        make_frame(1, 1'b1);
        send_queue(0);
        idle(2);
        checks += 3;
        if (wr_q.size() != 1 || wr_q[0] !== {8'h00, exp_words[0]}) begin
            errors++; $display("[TB] FAIL to_next_frame_write: got %0d writes want 1 of %h", wr_q.size(), exp_words[0]);
        end
        if (done_cnt != 1)  begin errors++; $display("[TB] FAIL to_next_frame_done: got %0d want 1", done_cnt); end
        if (error !== 1'b0) begin errors++; $display("[TB] FAIL to_next_frame_error: got %b want 0", error); end
    endtask

    task automatic test_timeout_edge();
        make_frame(1, 1'b1);
        wr_q.delete(); done_cnt = 0;
        send_byte(tx_q[0]);
        for (int i = 1; i < 4; i++) begin
            idle(TO - 1);
            send_byte(tx_q[i]);
        end
        idle(2);
        checks += 3;
        if (error !== 1'b0) begin errors++; $display("[TB] FAIL edge_error: got %b want 0", error); end
        if (done_cnt != 1)  begin errors++; $display("[TB] FAIL edge_done: got %0d want 1", done_cnt); end
        if (wr_q.size() != 1 || wr_q[0] !== {8'h00, exp_words[0]}) begin
            errors++; $display("[TB] FAIL edge_write: got %0d writes want 1 of %h", wr_q.size(), exp_words[0]);
        end
    endtask

    task automatic test_reset_mid();
        make_frame(5, 1'b1);
        wr_q.delete(); done_cnt = 0;
        for (int i = 0; i < 7; i++) send_byte(tx_q[i]);
        rst = 1'b1;
        idle(1);
        checks += 5;
        if (wr_en !== 1'b0)    begin errors++; $display("[TB] FAIL mid_wr_en: got %b want 0", wr_en); end
        if (cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL mid_hold: got %b want 0", cpu_hold); end
        if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL mid_busy: got %b want 0", busy); end
        if (wr_addr !== 8'h00 || wr_data !== 16'h0) begin errors++; $display("[TB] FAIL mid_wr_bus: got %h@%h want 0000@00", wr_data, wr_addr); end
        if (error !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL mid_flags: got err=%b done=%b want 0 0", error, done); end
        rst = 1'b0;
        idle(5);
        checks++;
        if (wr_q.size() != 3) begin errors++; $display("[TB] FAIL mid_write_count: got %0d want 3", wr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_random_frames();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream boot stage for the 16-bit CPU core: accepts a byte stream from the serial receiver, assembles 16-bit instruction words, and writes them into the instruction/data RAM starting at address 0. While loading, it holds the CPU stalled. It releases the CPU only after a checksum-verified transfer, so that the program counter restarts on a complete image.

## Interface
Parameters:
- ADDR_W, 8, RAM word-address width; matches program counter bits [7:0].
- TIMEOUT, 100000, maximum idle cycles between bytes inside a transfer before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle; no backpressure.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  16  RAM write data.
- wr_en  out  1  one-cycle RAM write strobe.
- cpu_hold  out  1  high = CPU stalled (PC and register writes frozen).
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky; set on checksum mismatch or timeout.

## Operation
- Frame format: COUNT byte, then 2×N data bytes (high byte first per word), then CSUM byte.
  - N = COUNT, except COUNT = 0 means N = 256.
  - CSUM = XOR of all 2N data bytes; COUNT is excluded.
- States: IDLE, HI, LO, CSUM.
  - IDLE + rx_valid: latch N, clear word index, clear running XOR, clear error, set busy and cpu_hold → HI.
  - HI + rx_valid: latch high byte, fold it into XOR → LO.
  - LO + rx_valid: form word {hi, rx_data}, fold into XOR, issue write. If this was the last word → CSUM, else → HI.
  - CSUM + rx_valid: if byte equals XOR, pulse done and clear cpu_hold; otherwise set error and keep cpu_hold = 1. Either way → IDLE, busy = 0.
- Write addressing: wr_addr = word index (0 .. N−1), incremented after each write. There is no wrap, because N ≤ 256 = 2^ADDR_W.
- Timeout: a counter runs in HI/LO/CSUM and clears on every accepted byte. On reaching TIMEOUT−1: set error, keep cpu_hold, → IDLE. Words already written stay in RAM.
- A byte arriving in the same cycle the counter expires is accepted; the byte wins and the counter clears.
- Error stays set until the next COUNT byte is accepted.
- A failed load leaves cpu_hold = 1 until a later load succeeds.
- Bytes in IDLE are always treated as COUNT; there is no sync word.

## Timing
- Reset values: wr_en = 0, wr_addr = 0, wr_data = 0, cpu_hold = 0, busy = 0, done = 0, error = 0, state = IDLE, counters = 0.
- A reset mid-transfer aborts immediately with no further writes. A partial image stays in RAM.
- All outputs are registered.
  - busy and cpu_hold rise the cycle after COUNT is accepted.
  - wr_en is high for exactly the cycle after the LO byte is accepted, with wr_addr/wr_data stable in that cycle.
  - done pulses, and cpu_hold and busy fall, on the cycle after CSUM is accepted.
- rx_valid may be asserted on consecutive cycles. One byte is accepted per cycle, so the maximum rate is one write every 2 cycles.
- The CPU samples cpu_hold every cycle. The loader never writes while cpu_hold = 0, so there is no port contention with CPU STR.

## Structure
- Shared package `cpu_pkg`:
  - loader state enum (IDLE, HI, LO, CSUM);
  - RAM address width constant (8), shared with the CPU PC slice;
  - default TIMEOUT.
- One natural sub-module, `prog_loader_timer`: a loadable down-counter with clear input and expiry output. The FSM, assembler, and XOR accumulator live in the top.

## Test plan
- Load COUNT=2, bytes 12 34 AB CD, CSUM=0x40 → writes 0x1234@0, 0xABCD@1; done pulses once; cpu_hold falls; error = 0.
- Same frame with CSUM=0x41 → both writes occur; error = 1; no done; cpu_hold stays 1. A following good frame clears error and releases cpu_hold.
- COUNT=0 with 512 bytes back-to-back (rx_valid every cycle) → 256 writes at addresses 0..255 with no gaps lost; last wr_addr = 255; done pulses.
- COUNT=1, byte 0x12, then silence for TIMEOUT cycles → error = 1, state IDLE, no write. The next byte is treated as COUNT.
- rx_valid arrives exactly on the timeout-expiry cycle → byte accepted; no error.
- rst asserted after 3 words of a 5-word frame → all outputs at reset values the next cycle; no further wr_en.
